// File: rtl/ram_nway_pkg.sv
// rtl/ram_nway_pkg.sv - shared types, sizes and byte-mask helper for the N-way cache data array
package ram_nway_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Sizes of the default configuration (AWIDTH=3, DWIDTH=32)
    localparam int DEPTH = 1 << 3;
    localparam int BYTES = 32 / 8;

    // Widest way entry the mask helper supports, in bytes
    localparam int MAX_BYTES = 64;

    // Expand one strobe bit per byte into a full bit mask; callers truncate to their width
    function automatic logic [MAX_BYTES*8-1:0] byte_mask(input logic [MAX_BYTES-1:0] be);
        logic [MAX_BYTES*8-1:0] m;
        for (int i = 0; i < MAX_BYTES; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/ram_way_bank.sv
// rtl/ram_way_bank.sv - one way of the data array: masked write, combinational read
module ram_way_bank #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_mask,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data
);

    logic [DWIDTH-1:0] mem [1 << AWIDTH];

    // Bit-masked write; the array is cleared by the top-level sweep, never by reset
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ram_sync_read_nway.sv
// rtl/ram_sync_read_nway.sv - N-way sync-read cache data array with init sweep; RAM_OUT_REG_EN adds an output register
module ram_sync_read_nway
    import ram_nway_pkg::*;
#(
    parameter int                AWIDTH     = 3,
    parameter int                DWIDTH     = 32,
    parameter int                WAYS       = 2,
    parameter logic [DWIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [AWIDTH-1:0]      addr,
    input  logic                   we,
    input  logic [WAYS-1:0]        way_sel,
    input  logic [DWIDTH/8-1:0]    byte_en,
    input  logic [DWIDTH-1:0]      din,
    output logic [WAYS*DWIDTH-1:0] dout,
    output logic                   dout_valid,
    output logic                   init_done
);

    state_t                   state;
    logic [AWIDTH-1:0]        sweep_cnt;
    logic [AWIDTH-1:0]        rd_addr_q;
    logic                     rd_pulse;
    logic                     accept;
    logic [WAYS-1:0]          wr_en;
    logic [AWIDTH-1:0]        wr_addr;
    logic [DWIDTH-1:0]        wr_mask;
    logic [DWIDTH-1:0]        wr_data;
    logic [WAYS*DWIDTH-1:0]   rd_all;

    assign accept = req_valid && req_ready;

    // Write port mux: the sweep owns every way while initialising, requests own it afterwards
    always_comb begin
        wr_en   = '0;
        wr_addr = addr;
        wr_mask = DWIDTH'(byte_mask(MAX_BYTES'(byte_en)));
        wr_data = din;
        if (state == INIT) begin
            wr_en   = '1;
            wr_addr = sweep_cnt;
            wr_mask = '1;
            wr_data = INIT_VALUE;
        end else if (accept && we) begin
            wr_en   = way_sel;
        end
    end

    // Init sweep FSM: one entry per cycle, then hand the array to the controller for good
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT;
            sweep_cnt <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (&sweep_cnt) begin
                        state     <= RUN;
                        req_ready <= 1'b1;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    req_ready <= 1'b1;
                    init_done <= 1'b1;
                end
                default: state <= INIT;
            endcase
        end
    end

    // Latch the set index of each accepted read; writes leave it alone
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr_q <= '0;
            rd_pulse  <= 1'b0;
        end else begin
            rd_pulse <= accept && !we;
            if (accept && !we) begin
                rd_addr_q <= addr;
            end
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        ram_way_bank #(
            .AWIDTH (AWIDTH),
            .DWIDTH (DWIDTH)
        ) u_bank (
            .clock   (clock),
            .wr_en   (wr_en[w]),
            .wr_addr (wr_addr),
            .wr_mask (wr_mask),
            .wr_data (wr_data),
            .rd_addr (rd_addr_q),
            .rd_data (rd_all[w*DWIDTH +: DWIDTH])
        );
    end

`ifdef RAM_OUT_REG_EN
    logic [WAYS*DWIDTH-1:0] dout_q;
    logic                   dout_valid_q;

    // Capture the read result once; later writes to that set do not disturb it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= rd_pulse;
            if (rd_pulse) begin
                dout_q <= rd_all;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
`else
    // Write-first view of the latched set; zero until the sweep has cleared the array
    assign dout       = init_done ? rd_all : '0;
    assign dout_valid = rd_pulse;
`endif

endmodule

// File: tb/tb_ram_sync_read_nway.sv
// tb/tb_ram_sync_read_nway.sv - scoreboard bench for ram_sync_read_nway (WAYS=4, DWIDTH=64, AWIDTH=6)
module tb_ram_sync_read_nway;

    localparam int AW    = 6;
    localparam int DW    = 64;
    localparam int W     = 4;
    localparam int DEPTH = 1 << AW;
    localparam int NB    = DW / 8;
`ifdef RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset_n;
    logic              req_valid;
    logic              we;
    logic [AW-1:0]     addr;
    logic [W-1:0]      way_sel;
    logic [NB-1:0]     byte_en;
    logic [DW-1:0]     din;
    logic              req_ready;
    logic              dout_valid;
    logic              init_done;
    logic [W*DW-1:0]   dout;

    ram_sync_read_nway #(
        .AWIDTH     (AW),
        .DWIDTH     (DW),
        .WAYS       (W),
        .INIT_VALUE ('0)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .addr       (addr),
        .we         (we),
        .way_sel    (way_sel),
        .byte_en    (byte_en),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .init_done  (init_done)
    );

    typedef struct {
        logic [W*DW-1:0] data;
        int              due;
    } exp_t;

    exp_t            sbq[$];
    logic [DW-1:0]   model [W][DEPTH];
    int              total   = 0;
    int              bad     = 0;
    int              cyc     = 0;
    int              n_reads = 0;
    int              n_valids = 0;
    logic            run_phase = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W*DW-1:0] act, input logic [W*DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W*DW-1:0] model_row(input int a);
        logic [W*DW-1:0] r;
        for (int w = 0; w < W; w++) r[w*DW +: DW] = model[w][a];
        return r;
    endfunction

    // Monitor: every dout_valid must match the oldest outstanding read, in its due cycle
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && dout_valid) begin
            n_valids++;
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got dout_valid=1 at cycle %0d with no read outstanding", cyc);
            end else begin
                e = sbq.pop_front();
                chk("read_data", dout, e.data);
                chk("read_cycle", cyc, e.due);
            end
        end
    end

    // Present one request for one clock; the model decides what the array must do with it
    task automatic issue(input logic v, input logic w_, input int a, input logic [W-1:0] ws,
                         input logic [NB-1:0] be, input logic [DW-1:0] d);
        req_valid = v;
        we        = w_;
        addr      = a[AW-1:0];
        way_sel   = ws;
        byte_en   = be;
        din       = d;
        if (v && run_phase) begin
            if (w_) begin
                for (int w = 0; w < W; w++)
                    for (int b = 0; b < NB; b++)
                        if (ws[w] && be[b]) model[w][a][b*8 +: 8] = d[b*8 +: 8];
            end else begin
                n_reads++;
                sbq.push_back('{model_row(a), cyc + LAT});
            end
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic apply_reset();
        run_phase = 1'b0;
        reset_n   = 1'b0;
        #1;
        chk("reset_req_ready", req_ready, 0);
        chk("reset_init_done", init_done, 0);
        chk("reset_dout_valid", dout_valid, 0);
        chk("reset_dout", dout, 0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    // Release reset with a read held on the bus and count cycles until the array takes requests
    task automatic sweep();
        int   n;
        logic quiet_bad;
        n         = 0;
        quiet_bad = 1'b0;
        req_valid = 1'b1;
        we        = 1'b0;
        addr      = 5;
        reset_n   = 1'b1;
        while (req_ready !== 1'b1 && n < 2 * DEPTH) begin
            @(posedge clock);
            #1;
            n++;
            if (req_ready !== 1'b1 && (init_done !== 1'b0 || dout !== '0 || dout_valid !== 1'b0))
                quiet_bad = 1'b1;
        end
        req_valid = 1'b0;
        chk("sweep_cycles", n, DEPTH);
        chk("sweep_outputs_quiet", quiet_bad, 0);
        chk("init_done_after_sweep", init_done, 1);
        for (int w = 0; w < W; w++)
            for (int a = 0; a < DEPTH; a++) model[w][a] = '0;
        run_phase = 1'b1;
    endtask

    task automatic drain();
        issue(0, 0, 0, '0, '0, '0);
        repeat (LAT + 1) begin @(posedge clock); #1; end
        chk("queue_drained", sbq.size(), 0);
    endtask

    initial begin
        logic [W*DW-1:0] old_row;
        reset_n = 1'b0; req_valid = 1'b1; we = 1'b0; addr = 5;
        way_sel = '1; byte_en = '1; din = '1;

        apply_reset();
        sweep();
        issue(1, 0, 5, '0, '0, '0);

        // byte-strobed write to one way, then read it back
        issue(1, 1, 3, 4'b0010, 8'h05, 64'hAABBCCDD_11223344);
        issue(1, 0, 3, '0, '0, '0);

        // write after read to the same set
        old_row = model_row(3);
        issue(1, 0, 3, '0, '0, '0);
        issue(1, 1, 3, 4'b0001, 8'hFF, 64'h12345678_9ABCDEF0);
`ifdef RAM_OUT_REG_EN
        chk("hold_after_write", dout, old_row);
`else
        chk("write_first", dout, model_row(3));
        chk("write_first_changed", (dout !== old_row), 1);
`endif
        drain();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            issue(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
                  W'($urandom), NB'($urandom), {$urandom, $urandom});
        end
        chk("ready_in_run", req_ready, 1);

        // stream every set back to back
        for (int a = 0; a < DEPTH; a++) issue(1, 0, a, '0, '0, '0);
        drain();

        // load set 0 with data, leave it latched, then reset mid-operation and mid-sweep
        issue(1, 1, 0, '1, '1, 64'hDEADBEEF_CAFEF00D);
        issue(1, 0, 0, '0, '0, '0);
        drain();
        apply_reset();
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        chk("mid_sweep_not_ready", req_ready, 0);
        apply_reset();
        sweep();
        for (int a = 0; a < DEPTH; a++) issue(1, 0, a, '0, '0, '0);
        drain();

        chk("valid_count", n_valids, n_reads);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
